// File: rtl/comp_pkg.sv
// comp_pkg: shared types and elaboration checks for the chunked complement unit.
//   Provides the 2-bit mode encoding, the FSM state encoding and a geometry check
//   for the WIDTH/CHUNK pair.
package comp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ONES = 2'b01,
        MODE_TWOS = 2'b10,
        MODE_ABS  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // WIDTH must split into at least two whole chunks.
    function automatic bit geometry_ok(int width, int chunk);
        return chunk > 0 && width % chunk == 0 && width / chunk >= 2;
    endfunction

endpackage

// File: rtl/complement_seq_if.sv
// complement_seq_if: operand/result handshake bundle for complement_seq.
//   in_valid/in_ready/in_data/in_mode  : operand side
//   out_valid/out_ready/out_data/out_ovf/out_zero : result side
//   master = producer/consumer around the unit, slave = the unit itself.
interface complement_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_zero
    );
endinterface

// File: rtl/comp_chunk.sv
// comp_chunk: combinational CHUNK-bit conditional-invert-and-increment slice.
//   data   : operand chunk
//   invert : ones'-complement the chunk before adding
//   cin    : carry in from the previous chunk
//   sum    : result chunk
//   cout   : carry out to the next chunk
module comp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] data,
    input  logic             invert,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    assign {cout, sum} = {1'b0, data ^ {CHUNK{invert}}} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/complement_seq.sv
// complement_seq: multi-cycle pass/ones/twos/abs complement, CHUNK bits per cycle, LSB first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : complement_seq_if slave (operand handshake in, result handshake out,
//           out_ovf for negating the most-negative value, out_zero for a zero result)
module complement_seq
    import comp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input logic          clk,
    input logic          rst_n,
    complement_seq_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = $clog2(NCHUNK);
    localparam logic [IDXW-1:0]  LAST = IDXW'(NCHUNK - 1);
    localparam logic [CHUNK-1:0] TOP  = CHUNK'(1) << (CHUNK - 1);

    if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
        $error("complement_seq: WIDTH must be a multiple of CHUNK with at least two chunks");
    end

    state_t           state, state_nx;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a, res;
    logic             carry, invert, neg, msb, low_zero, res_zero, ovf, zero;
    logic [CHUNK-1:0] sum;
    logic             cout, accept, last, flip_in, lz_nx, rz_nx;

    assign accept  = state == IDLE && bus.in_valid;
    assign last    = idx == LAST;
    assign flip_in = bus.in_mode == MODE_TWOS || (bus.in_mode == MODE_ABS && bus.in_data[WIDTH-1]);

    // Operand shifts right each cycle, so the active chunk is always the low slice.
    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .data   (a[CHUNK-1:0]),
        .invert (invert),
        .cin    (carry),
        .sum    (sum),
        .cout   (cout)
    );

    // Overflow needs every operand bit below the MSB to be zero; the top chunk's MSB is masked off.
    assign lz_nx = low_zero && ((last ? a[CHUNK-1:0] & ~TOP : a[CHUNK-1:0]) == '0);
    assign rz_nx = res_zero && sum == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.in_valid ? RUN : IDLE;
            RUN:     state_nx = last ? DONE : RUN;
            DONE:    state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            invert   <= 1'b0;
            neg      <= 1'b0;
            msb      <= 1'b0;
            a        <= '0;
            res      <= '0;
            low_zero <= 1'b0;
            res_zero <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a        <= bus.in_data;
                msb      <= bus.in_data[WIDTH-1];
                invert   <= flip_in || bus.in_mode == MODE_ONES;
                carry    <= flip_in;
                neg      <= flip_in;
                idx      <= '0;
                low_zero <= 1'b1;
                res_zero <= 1'b1;
            end else if (state == RUN) begin
                a        <= a >> CHUNK;
                res      <= {sum, res[WIDTH-1:CHUNK]};
                carry    <= cout;
                idx      <= idx + IDXW'(1);
                low_zero <= lz_nx;
                res_zero <= rz_nx;
                if (last) begin
                    ovf  <= neg && msb && lz_nx;
                    zero <= rz_nx;
                end
            end
        end
    end

    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.out_data  = res;
    assign bus.out_ovf   = ovf;
    assign bus.out_zero  = zero;
endmodule

// File: tb/tb_complement_seq.sv
// tb_complement_seq: scoreboard bench for complement_seq at 64/8 and 32/4 geometries.
module tb_complement_seq;
    import comp_pkg::*;

    typedef struct packed {
        logic [63:0] r;
        logic        ovf;
        logic        zero;
    } exp_t;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst32_n = 1'b0;
    always #5 clk = ~clk;

    complement_seq_if #(.WIDTH(64)) b ();
    complement_seq_if #(.WIDTH(32)) c ();

    complement_seq #(.WIDTH(64), .CHUNK(8)) u64 (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    complement_seq #(.WIDTH(32), .CHUNK(4)) u32 (.clk(clk), .rst_n(rst32_n), .bus(c.slave));

    exp_t q64[$];
    exp_t q32[$];
    int checks = 0;
    int errors = 0;

    // Reference: plain arithmetic on the operand, masked to the instance width.
    function automatic exp_t model(logic [63:0] a_in, logic [1:0] m, int w);
        logic [63:0] mask, min, a;
        logic neg, flip;
        exp_t e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        min    = 64'd1 << (w - 1);
        a      = a_in & mask;
        neg    = (a & min) != 0;
        flip   = m == MODE_TWOS || (m == MODE_ABS && neg);
        e.r    = (m == MODE_ONES ? ~a : flip ? -a : a) & mask;
        e.ovf  = flip && a == min;
        e.zero = e.r == 0;
        return e;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(bit s);
        return s ? c.in_ready : b.in_ready;
    endfunction

    function automatic logic vld(bit s);
        return s ? c.out_valid : b.out_valid;
    endfunction

    task automatic send(bit s, logic [63:0] a, logic [1:0] m);
        int n = 0;
        while (!rdy(s) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(s ? "u32 in_ready before send" : "u64 in_ready before send", {63'd0, rdy(s)}, 64'd1);
        if (s) begin
            c.in_valid = 1'b1; c.in_data = a[31:0]; c.in_mode = m;
            q32.push_back(model(a, m, 32));
        end else begin
            b.in_valid = 1'b1; b.in_data = a; b.in_mode = m;
            q64.push_back(model(a, m, 64));
        end
        @(posedge clk); #1;
        // Scramble inputs after accept; the unit must ignore them.
        b.in_valid = 1'b0; b.in_data = {$urandom, $urandom}; b.in_mode = 2'($urandom);
        c.in_valid = 1'b0; c.in_data = $urandom; c.in_mode = 2'($urandom);
    endtask

    task automatic wait_valid(bit s, output int n);
        n = 0;
        while (!vld(s) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic op(bit s, logic [63:0] a, logic [1:0] m);
        int n;
        send(s, a, m);
        wait_valid(s, n);
        chk(s ? "u32 latency" : "u64 latency", 64'(n), 64'd8);
        @(posedge clk); #1;
        chk(s ? "u32 in_ready after handshake" : "u64 in_ready after handshake", {63'd0, rdy(s)}, 64'd1);
        chk(s ? "u32 out_valid after handshake" : "u64 out_valid after handshake", {63'd0, vld(s)}, 64'd0);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && b.out_valid && b.out_ready) begin
            chk("u64 scoreboard has entry", 64'(q64.size() != 0), 64'd1);
            if (q64.size() != 0) begin
                e = q64.pop_front();
                chk("u64 out_data", b.out_data, e.r);
                chk("u64 out_ovf", {63'd0, b.out_ovf}, {63'd0, e.ovf});
                chk("u64 out_zero", {63'd0, b.out_zero}, {63'd0, e.zero});
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst32_n && c.out_valid && c.out_ready) begin
            chk("u32 scoreboard has entry", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                chk("u32 out_data", {32'd0, c.out_data}, e.r);
                chk("u32 out_ovf", {63'd0, c.out_ovf}, {63'd0, e.ovf});
                chk("u32 out_zero", {63'd0, c.out_zero}, {63'd0, e.zero});
            end
        end
    end

    initial begin
        exp_t e;
        int n;
        logic [63:0] a;
        b.in_valid = 1'b0; b.in_data = '0; b.in_mode = '0; b.out_ready = 1'b1;
        c.in_valid = 1'b0; c.in_data = '0; c.in_mode = '0; c.out_ready = 1'b1;
        #12;
        chk("reset in_ready", {63'd0, b.in_ready}, 64'd1);
        chk("reset out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("reset out_data", b.out_data, 64'd0);
        chk("reset out_ovf", {63'd0, b.out_ovf}, 64'd0);
        chk("reset out_zero", {63'd0, b.out_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rst32_n = 1'b1;
        @(posedge clk); #1;

        op(0, 64'h5, MODE_TWOS);
        op(0, 64'h0, MODE_TWOS);
        op(0, MIN64, MODE_TWOS);
        op(0, MIN64, MODE_ONES);
        op(0, 64'hFFFF_FFFF_FFFF_FFF6, MODE_ABS);
        op(0, 64'h7, MODE_ABS);
        op(0, 64'h1234, MODE_PASS);
        op(0, MIN64, MODE_ABS);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = MIN64;
                1:       a = 64'd0;
                default: a = {$urandom, $urandom};
            endcase
            op(0, a, 2'($urandom_range(0, 3)));
        end

        // Backpressure: hold DONE for 5 cycles with a stray in_valid pulse.
        a = {$urandom, $urandom};
        e = model(a, MODE_TWOS, 64);
        b.out_ready = 1'b0;
        send(0, a, MODE_TWOS);
        wait_valid(0, n);
        chk("u64 backpressure latency", 64'(n), 64'd8);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                b.in_valid = 1'b1; b.in_data = {$urandom, $urandom}; b.in_mode = MODE_PASS;
            end
            @(posedge clk); #1;
            b.in_valid = 1'b0;
            chk("bp out_valid held", {63'd0, b.out_valid}, 64'd1);
            chk("bp in_ready low", {63'd0, b.in_ready}, 64'd0);
            chk("bp out_data stable", b.out_data, e.r);
            chk("bp out_ovf stable", {63'd0, b.out_ovf}, {63'd0, e.ovf});
        end
        b.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp in_ready after release", {63'd0, b.in_ready}, 64'd1);
        repeat (12) @(posedge clk);
        #1;
        chk("bp stray pulse ignored", {63'd0, b.out_valid}, 64'd0);
        chk("bp queue drained", 64'(q64.size()), 64'd0);

        // Reset during chunk 3.
        send(0, {$urandom, $urandom}, MODE_TWOS);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid-run reset out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("mid-run reset in_ready", {63'd0, b.in_ready}, 64'd1);
        chk("mid-run reset out_data", b.out_data, 64'd0);
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, 64'h1, MODE_TWOS);

        // Reset while holding DONE.
        b.out_ready = 1'b0;
        send(0, 64'h3, MODE_ONES);
        wait_valid(0, n);
        chk("done latency", 64'(n), 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-done reset out_valid", {63'd0, b.out_valid}, 64'd0);
        chk("mid-done reset in_ready", {63'd0, b.in_ready}, 64'd1);
        chk("mid-done reset out_data", b.out_data, 64'd0);
        q64.delete();
        b.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        op(0, 64'h0, MODE_ONES);

        // 32-bit / 4-bit geometry.
        send(1, {32'd0, $urandom}, MODE_TWOS);
        repeat (3) @(posedge clk);
        #3;
        rst32_n = 1'b0;
        #1;
        chk("u32 mid-run reset out_valid", {63'd0, c.out_valid}, 64'd0);
        chk("u32 mid-run reset in_ready", {63'd0, c.in_ready}, 64'd1);
        q32.delete();
        @(negedge clk);
        rst32_n = 1'b1;
        @(posedge clk); #1;
        op(1, 64'h1, MODE_TWOS);
        op(1, 64'hFFFF_FFF6, MODE_ABS);
        op(1, 64'h8000_0000, MODE_TWOS);
        op(1, 64'h8000_0000, MODE_ONES);
        op(1, 64'h0, MODE_TWOS);
        for (int i = 0; i < 10; i++) op(1, {32'd0, $urandom}, 2'($urandom_range(0, 3)));

        repeat (3) @(posedge clk);
        #1;
        chk("u64 queue empty at end", 64'(q64.size()), 64'd0);
        chk("u32 queue empty at end", 64'(q32.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
